sophie2_osc: RTL and testbench



---
 rtl/sophie2_osc.sv | 167 ++++++++++++++++
 tb/tb_sophie2_osc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sophie2_osc.sv
// Sixteen-step chord sequencer: 100 Hz timebase, one-hot note-on gates, chord-table oscillator frequencies.
// Latency: every output is registered; gates and end_count follow the qualifying tick edge, frequencies follow chord_r by one clk.
// Backpressure: none; free-running. SOPHIE2_FAST_TICK_EN shortens the divider to 500 clocks for simulation.
module sophie2_osc #(
    parameter int TICK_DIV = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctrl,
    input  logic [9:0]  userInput,
    input  logic        enable,
    output logic [19:0] memfrequency0,
    output logic [19:0] memfrequency1,
    output logic [19:0] memfrequency2,
    output logic [19:0] memfrequency3,
    output logic [19:0] memfrequency4,
    output logic [19:0] memfrequency5,
    output logic [19:0] memfrequency6,
    output logic [19:0] memfrequency7,
    output logic [19:0] memfrequency8,
    output logic [19:0] memfrequency9,
    output logic [19:0] memfrequency10,
    output logic [19:0] memfrequency11,
    output logic [19:0] memfrequency12,
    output logic [19:0] memfrequency13,
    output logic [19:0] memfrequency14,
    output logic [19:0] memfrequency15,
    output logic [15:0] Triggeradsr,
    output logic        end_count,
    output logic        clk100hzout2
);

`ifdef SOPHIE2_FAST_TICK_EN
    localparam int DIV = 500;
`else
    localparam int DIV = TICK_DIV;
`endif
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2 - 1);

    // Base voice frequencies in centihertz, octave 0.
    function automatic logic [19:0] base_freq(input logic [1:0] chord, input logic [1:0] voice);
        logic [19:0] f;
        f = 20'd0;
        case (chord)
            2'd0: case (voice)
                2'd0: f = 20'd13081;
                2'd1: f = 20'd16481;
                2'd2: f = 20'd19600;
                default: f = 20'd24694;
            endcase
            2'd1: case (voice)
                2'd0: f = 20'd11000;
                2'd1: f = 20'd13081;
                2'd2: f = 20'd16481;
                default: f = 20'd19600;
            endcase
            2'd2: case (voice)
                2'd0: f = 20'd8731;
                2'd1: f = 20'd11000;
                2'd2: f = 20'd13081;
                default: f = 20'd16481;
            endcase
            default: case (voice)
                2'd0: f = 20'd9800;
                2'd1: f = 20'd12347;
                2'd2: f = 20'd14683;
                default: f = 20'd17461;
            endcase
        endcase
        return f;
    endfunction

    function automatic logic [19:0] slot_freq(input logic [1:0] chord, input logic [3:0] slot);
        return base_freq(chord, slot[1:0]) << slot[3:2];
    endfunction

    logic [DW-1:0] div_cnt;
    logic [9:0]    len_r;
    logic [1:0]    chord_r;
    logic [9:0]    tick_cnt;
    logic [3:0]    step;
    logic [19:0]   freq_r [16];

    logic          tick;
    logic          half_tick;
    logic [9:0]    len_eff;
    logic          step_adv;
    logic [3:0]    step_nxt;

    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        half_tick = (div_cnt == DIV_HALF);
        len_eff   = (len_r == 10'd0) ? 10'd1 : len_r;
        // >= rather than == so a shortened length ends the current step at the next tick.
        step_adv  = tick && (tick_cnt >= (len_eff - 10'd1));
        step_nxt  = step_adv ? step + 4'd1 : step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            clk100hzout2 <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick || half_tick)
                clk100hzout2 <= ~clk100hzout2;
        end
    end

    // New parameters take effect from the clk after capture; an advance on the capture edge uses the old length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r   <= 10'd100;
            chord_r <= 2'd0;
        end else if (enable) begin
            len_r   <= userInput;
            chord_r <= ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt    <= 10'd0;
            step        <= 4'd0;
            Triggeradsr <= 16'h0000;
            end_count   <= 1'b0;
        end else begin
            if (step_adv)
                tick_cnt <= 10'd0;
            else if (tick)
                tick_cnt <= tick_cnt + 10'd1;
            step        <= step_nxt;
            Triggeradsr <= 16'h0001 << step_nxt;
            end_count   <= step_adv && (step == 4'd15);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 16; k++)
                freq_r[k] <= slot_freq(2'd0, 4'(k));
        end else begin
            for (int k = 0; k < 16; k++)
                freq_r[k] <= slot_freq(chord_r, 4'(k));
        end
    end

    assign memfrequency0  = freq_r[0];
    assign memfrequency1  = freq_r[1];
    assign memfrequency2  = freq_r[2];
    assign memfrequency3  = freq_r[3];
    assign memfrequency4  = freq_r[4];
    assign memfrequency5  = freq_r[5];
    assign memfrequency6  = freq_r[6];
    assign memfrequency7  = freq_r[7];
    assign memfrequency8  = freq_r[8];
    assign memfrequency9  = freq_r[9];
    assign memfrequency10 = freq_r[10];
    assign memfrequency11 = freq_r[11];
    assign memfrequency12 = freq_r[12];
    assign memfrequency13 = freq_r[13];
    assign memfrequency14 = freq_r[14];
    assign memfrequency15 = freq_r[15];

endmodule

// File: tb/tb_sophie2_osc.sv
// Randomized bench for sophie2_osc against an elapsed-time reference model, divider set to 500 clocks.
module tb_sophie2_osc;
    localparam int DIV = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ctrl = 2'd0;
    logic [9:0]  user_input = 10'd0;
    logic        enable = 1'b0;
    logic [19:0] mf [16];
    logic [15:0] trig;
    logic        end_count;
    logic        sq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: clocks elapsed since reset, ticks spent in the current step, current slot.
    int m_edges, m_prog, m_step, m_len, m_chord, m_fchord, m_trig, m_end, m_sq;
    int base [4][4] = '{'{13081, 16481, 19600, 24694},
                        '{11000, 13081, 16481, 19600},
                        '{ 8731, 11000, 13081, 16481},
                        '{ 9800, 12347, 14683, 17461}};

    always #10 clk = ~clk;

    sophie2_osc #(.TICK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl), .userInput(user_input), .enable(enable),
        .memfrequency0(mf[0]),   .memfrequency1(mf[1]),   .memfrequency2(mf[2]),   .memfrequency3(mf[3]),
        .memfrequency4(mf[4]),   .memfrequency5(mf[5]),   .memfrequency6(mf[6]),   .memfrequency7(mf[7]),
        .memfrequency8(mf[8]),   .memfrequency9(mf[9]),   .memfrequency10(mf[10]), .memfrequency11(mf[11]),
        .memfrequency12(mf[12]), .memfrequency13(mf[13]), .memfrequency14(mf[14]), .memfrequency15(mf[15]),
        .Triggeradsr(trig), .end_count(end_count), .clk100hzout2(sq)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_freq(input int chord, input int slot);
        return base[chord][slot % 4] << (slot / 4);
    endfunction

    task automatic model_reset();
        m_edges = 0; m_prog = 0; m_step = 0; m_len = 100; m_chord = 0;
        m_fchord = 0; m_trig = 0; m_end = 0; m_sq = 0;
    endtask

    task automatic model_edge();
        int ph;
        int eff;
        ph  = m_edges % DIV;
        eff = (m_len == 0) ? 1 : m_len;
        m_end = 0;
        if (ph == DIV / 2 - 1 || ph == DIV - 1)
            m_sq ^= 1;
        if (ph == DIV - 1) begin
            if (m_prog >= eff - 1) begin
                m_prog = 0;
                m_end  = (m_step == 15);
                m_step = (m_step + 1) % 16;
            end else begin
                m_prog++;
            end
        end
        m_trig   = 1 << m_step;
        m_fchord = m_chord;
        if (enable) begin
            m_len   = int'(user_input);
            m_chord = int'(ctrl);
        end
        m_edges++;
    endtask

    task automatic check_outputs();
        int k;
        k = $urandom_range(15);
        check_val("trig", 32'(trig), 32'(m_trig));
        check_val("end_count", 32'(end_count), 32'(m_end));
        check_val("clk100", 32'(sq), 32'(m_sq));
        check_val("freq_rand", 32'(mf[k]), 32'(exp_freq(m_fchord, k)));
    endtask

    // One clock: model advances on the edge, outputs compared on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (!enable) begin
                ctrl       = 2'($urandom);
                user_input = 10'($urandom);
            end
            cycle();
        end
    endtask

    initial begin
        int start_step;
        int guard;
        model_reset();
        @(negedge clk);
        check_val("rst_trig", 32'(trig), 32'h0);
        check_val("rst_end", 32'(end_count), 32'h0);
        check_val("rst_clk100", 32'(sq), 32'h0);
        check_val("rst_f0", 32'(mf[0]), 32'd13081);
        check_val("rst_f15", 32'(mf[15]), 32'd197552);
        repeat (19) @(negedge clk);
        enable = 1'b1; user_input = 10'd1; ctrl = 2'd0;
        reset = 1'b0;
        cycle();
        check_val("first_edge_trig", 32'(trig), 32'h0001);

        // Full loop at one tick per step.
        run(16 * DIV + 100);

        enable = 1'b1; ctrl = 2'd1;
        cycle();
        enable = 1'b0; ctrl = 2'd3;
        cycle();
        check_val("chord1_f0", 32'(mf[0]), 32'd11000);
        check_val("chord1_f4", 32'(mf[4]), 32'd22000);
        run(5);
        check_val("hold_f0", 32'(mf[0]), 32'd11000);
        check_val("hold_f4", 32'(mf[4]), 32'd22000);

        enable = 1'b1; user_input = 10'd0;
        run(4 * DIV);

        // Shorten a long step midway; it must end at the very next tick.
        user_input = 10'd20;
        guard = 0;
        do begin cycle(); guard++; end while (!(m_prog == 10 && (m_edges % DIV) == DIV / 3) && guard < 40 * DIV);
        check_val("mid_step_reached", 32'(guard < 40 * DIV), 32'd1);
        start_step = m_step;
        user_input = 10'd5;
        run(DIV);
        check_val("shorten_adv", 32'(trig), 32'(1 << ((start_step + 1) % 16)));

        // Random parameter loads with short lengths.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(299) == 0) begin
                enable     = 1'b1;
                user_input = 10'($urandom_range(3));
                ctrl       = 2'($urandom);
            end else begin
                enable = 1'b0;
            end
            cycle();
        end
        enable = 1'b0;

        guard = 0;
        while (m_step != 7 && guard < 60 * DIV) begin run(1); guard++; end
        check_val("reach_step7", 32'(m_step), 32'd7);
        run(DIV / 4);
        reset = 1'b1;
        #1;
        check_val("async_rst_trig", 32'(trig), 32'h0);
        check_val("async_rst_end", 32'(end_count), 32'h0);
        check_val("async_rst_clk100", 32'(sq), 32'h0);
        check_val("async_rst_f0", 32'(mf[0]), 32'd13081);
        model_reset();
        run(3);
        enable = 1'b1; user_input = 10'd2; ctrl = 2'd2;
        reset = 1'b0;
        cycle();
        check_val("restart_trig", 32'(trig), 32'h0001);
        run(3 * DIV);
        for (int k = 0; k < 16; k++)
            check_val("final_freq", 32'(mf[k]), 32'(exp_freq(m_fchord, k)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
